fsm_trigger_sequencer: RTL and testbench
========================================

Name: fsm_trigger_sequencer

Overview:
Parametrised successor to the single-shot calibration FSM. After a start command it waits for a frame-grabber (FG) rising edge and an FG settling delay. It then emits a burst of N triggers, each one aligned to a phase-signal rising edge plus a programmable phase shift. Delays, pulse length, burst count and channel mask are runtime inputs latched at start. The block also adds input synchronisation, edge-wait timeouts, abort, and busy/done/error status. It sits between the control register file and the trigger fan-out.

Parameters:
N_CH, 4, number of trigger output channels
CNT_W, 32, width of the delay/length/timeout counter
BURST_W, 8, width of the burst-count input
SYNC_STAGES, 2, synchroniser flops on fg_signal and phase_signal (minimum 2)
TIMEOUT, 50_000_000, maximum cycles spent in an edge-wait state; 0 disables the timeout

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start_signal  in  1  level; sampled only in IDLE
abort  in  1  returns the FSM to IDLE from any state on the next edge
fg_signal  in  1  asynchronous frame-grabber strobe
phase_signal  in  1  asynchronous phase reference
cfg_fg_delay  in  CNT_W  FG settling delay in cycles
cfg_phase_shift  in  CNT_W  delay from phase edge to pulse, in cycles
cfg_trig_len  in  CNT_W  pulse width in cycles
cfg_burst  in  BURST_W  pulses per run
cfg_ch_mask  in  N_CH  enabled output channels
output_trigger  out  N_CH  trigger pulses
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle strobe on normal completion
error_timeout  out  1  sticky; cleared by reset or the next accepted start

Behaviour:
- Reset: state=IDLE; counter=0; pulses_left=0; output_trigger=0; busy=0; done=0; error_timeout=0; synchroniser and history flops=0.
- Reset has priority over every other input.
- Edge detection: each input passes through SYNC_STAGES flops, then a 1-flop history register. rise = sync_out & ~hist. Total latency from an input edge to rise is SYNC_STAGES+1 cycles.
- All cfg_* inputs are latched on the accepted start. Later changes have no effect on the current run.
- Zero-value rules:
  - cfg_burst=0 is treated as 1.
  - cfg_trig_len=0 is treated as 1.
  - cfg_fg_delay=0 or cfg_phase_shift=0 means the delay state lasts exactly 1 cycle.
- A delay of D>0 lasts exactly D cycles: the counter runs 0..D-1 and the FSM exits when counter==D-1.
- States:
  - IDLE: if start_signal & ~abort, latch cfg, clear error_timeout, set pulses_left=burst, go to WAIT_FG.
  - WAIT_FG: on rise_fg go to FG_DELAY with counter=0. Otherwise increment counter; if TIMEOUT!=0 and counter==TIMEOUT-1, set error_timeout and go to IDLE.
  - FG_DELAY: counts cfg_fg_delay cycles, then goes to WAIT_PHASE with counter=0.
  - WAIT_PHASE: on rise_phase go to PHASE_DELAY. Timeout is handled as in WAIT_FG.
  - PHASE_DELAY: counts cfg_phase_shift cycles, then goes to PULSE.
  - PULSE: output_trigger = latched mask for exactly trig_len cycles. output_trigger is registered and asserts on the first PULSE cycle.
  - After the last pulse cycle, decrement pulses_left:
    - if the result is 0, pulse done for 1 cycle and go to IDLE;
    - otherwise return to WAIT_PHASE. The FG edge is not re-awaited.
- Edge handling: phase edges arriving outside WAIT_PHASE are ignored, not queued. A rise_phase in the same cycle the FSM enters WAIT_PHASE is not seen; only edges while in the state count.
- Abort: the next cycle gives state=IDLE, output_trigger=0, no done, and error_timeout unchanged. If abort and start are high in IDLE together, start is ignored.
- Unused encodings go to IDLE.
- The counter never wraps: CNT_W must hold max(cfg, TIMEOUT).

Decomposition:
- Package trig_seq_pkg holds: the state enum (IDLE, WAIT_FG, FG_DELAY, WAIT_PHASE, PHASE_DELAY, PULSE), CNT_W and the default delay constants (400_000, 139, 100).
- One sub-module, sync_edge_detect (parameter SYNC_STAGES), is instantiated twice: once for fg_signal and once for phase_signal.

Test Plan:
- Single shot, timing check:
  - Stimulus: fg_delay=10, phase_shift=139, trig_len=100, burst=1, mask=4'b0101; start, then an FG edge, then a phase edge 50 cycles after FG_DELAY ends.
  - Response: output_trigger=4'b0101 for exactly 100 cycles, starting 139 cycles after the phase edge plus 3 cycles of sync latency. done pulses once. busy falls with done.
- Burst with missed edge:
  - Stimulus: burst=3, phase edges every 300 cycles, trig_len=20.
  - Response: three pulses, each 139+3 cycles after its own edge, no FG re-wait, a single done.
  - Stimulus: an extra phase edge during PULSE.
  - Response: that edge is ignored.
- Timeout:
  - Stimulus: TIMEOUT=1000, no FG edge after start.
  - Response: error_timeout=1 at cycle 1000, state=IDLE, no trigger.
  - Stimulus: the next start.
  - Response: error_timeout clears.
- Abort mid-pulse:
  - Stimulus: abort at pulse cycle 40 of 100.
  - Response: output_trigger=0 the next cycle, busy=0, no done, later phase edges produce nothing.
- Zero configuration:
  - Stimulus: fg_delay=0, phase_shift=0, trig_len=0, burst=0.
  - Response: exactly one 1-cycle pulse, 1 cycle after PHASE_DELAY is entered.
- Reset mid-run:
  - Stimulus: reset during PHASE_DELAY, held 1 cycle.
  - Response: all outputs 0 the next cycle. start_signal held high through reset begins a new run on the first post-reset cycle.

Source files
------------

// File: rtl/trig_seq_pkg.sv
// Shared constants for the trigger sequencer.
// Contents:
//   state_t and the St* state encodings (plain localparams, so older tools
//   can use them too)
//   DEF_CNT_W      default width of the delay/length/timeout counter
//   DEF_* delays   power-on defaults carried over from the single-shot
//                  calibration FSM, for use by the register file
package trig_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle       = 3'd0;
   localparam state_t StWaitFg     = 3'd1;
   localparam state_t StFgDelay    = 3'd2;
   localparam state_t StWaitPhase  = 3'd3;
   localparam state_t StPhaseDelay = 3'd4;
   localparam state_t StPulse      = 3'd5;

   localparam int unsigned DEF_CNT_W       = 32;
   localparam int unsigned DEF_FG_DELAY    = 400_000;
   localparam int unsigned DEF_PHASE_SHIFT = 139;
   localparam int unsigned DEF_TRIG_LEN    = 100;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a one-flop history register.
// Produces a single-cycle rising-edge strobe SYNC_STAGES+1 cycles after
// the asynchronous input rises.
// Ports:
//   clock     system clock
//   reset     synchronous, active-high reset
//   async_in  asynchronous input
//   rise      one-cycle strobe on a synchronised rising edge
module sync_edge_detect
   import trig_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/fsm_trigger_sequencer.sv
// Burst trigger sequencer. After an accepted start it waits for a
// frame-grabber edge plus a settling delay, then fires cfg_burst pulses,
// each placed cfg_phase_shift cycles after its own phase-reference edge.
// Ports:
//   clock, reset                synchronous active-high reset
//   start_signal                level, only looked at in IDLE
//   abort                       forces IDLE on the next edge
//   fg_signal, phase_signal     asynchronous strobes, synchronised here
//   cfg_*                       run configuration, latched on start
//   output_trigger              registered per-channel pulses
//   busy, done, error_timeout   status
module fsm_trigger_sequencer
   import trig_seq_pkg::*;
#(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned BURST_W     = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 50_000_000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start_signal,
   input  logic               abort,
   input  logic               fg_signal,
   input  logic               phase_signal,
   input  logic [CNT_W-1:0]   cfg_fg_delay,
   input  logic [CNT_W-1:0]   cfg_phase_shift,
   input  logic [CNT_W-1:0]   cfg_trig_len,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic [N_CH-1:0]    cfg_ch_mask,
   output logic [N_CH-1:0]    output_trigger,
   output logic               busy,
   output logic               done,
   output logic               error_timeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   logic rise_fg;
   logic rise_phase;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_fg (
      .clock   (clock),
      .reset   (reset),
      .async_in(fg_signal),
      .rise    (rise_fg)
   );

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_phase (
      .clock   (clock),
      .reset   (reset),
      .async_in(phase_signal),
      .rise    (rise_phase)
   );

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   counter_q, counter_d;
   logic [BURST_W-1:0] pulses_q, pulses_d;
   logic               error_q, error_d;
   logic               done_q, done_d;
   logic [N_CH-1:0]    trig_q, trig_d;

   // Latched configuration, stored as the last counter value of each phase
   // so zero-valued settings collapse to a single cycle.
   logic [CNT_W-1:0]   fg_last_q;
   logic [CNT_W-1:0]   phase_last_q;
   logic [CNT_W-1:0]   len_last_q;
   logic [N_CH-1:0]    mask_q;

   logic accept;
   logic timeout_hit;

   assign accept      = (state_q == StIdle) && start_signal && !abort;
   assign timeout_hit = (TIMEOUT != 0) && (counter_q == TIMEOUT_LAST);

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      pulses_d  = pulses_q;
      error_d   = error_q;
      done_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               error_d   = 1'b0;
               pulses_d  = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;
               counter_d = '0;
               state_d   = StWaitFg;
            end
         end
         StWaitFg: begin
            if (rise_fg) begin
               counter_d = '0;
               state_d   = StFgDelay;
            end else if (timeout_hit) begin
               error_d   = 1'b1;
               counter_d = '0;
               state_d   = StIdle;
            end else begin
               counter_d = counter_q + CNT_W'(1);
            end
         end
         StFgDelay: begin
            if (counter_q == fg_last_q) begin
               counter_d = '0;
               state_d   = StWaitPhase;
            end else begin
               counter_d = counter_q + CNT_W'(1);
            end
         end
         StWaitPhase: begin
            if (rise_phase) begin
               counter_d = '0;
               state_d   = StPhaseDelay;
            end else if (timeout_hit) begin
               error_d   = 1'b1;
               counter_d = '0;
               state_d   = StIdle;
            end else begin
               counter_d = counter_q + CNT_W'(1);
            end
         end
         StPhaseDelay: begin
            if (counter_q == phase_last_q) begin
               counter_d = '0;
               state_d   = StPulse;
            end else begin
               counter_d = counter_q + CNT_W'(1);
            end
         end
         StPulse: begin
            if (counter_q == len_last_q) begin
               counter_d = '0;
               pulses_d  = pulses_q - BURST_W'(1);
               if (pulses_q == BURST_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  // Later pulses re-sync to the phase reference only.
                  state_d = StWaitPhase;
               end
            end else begin
               counter_d = counter_q + CNT_W'(1);
            end
         end
         default: begin
            counter_d = '0;
            state_d   = StIdle;
         end
      endcase

      // Abort wins over everything but reset and leaves the error flag alone.
      if (abort) begin
         state_d   = StIdle;
         counter_d = '0;
         pulses_d  = '0;
         done_d    = 1'b0;
         error_d   = error_q;
      end

      // Registered output: high in exactly the cycles the FSM sits in PULSE.
      trig_d = (state_d == StPulse) ? mask_q : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         counter_q    <= '0;
         pulses_q     <= '0;
         error_q      <= 1'b0;
         done_q       <= 1'b0;
         trig_q       <= '0;
         fg_last_q    <= '0;
         phase_last_q <= '0;
         len_last_q   <= '0;
         mask_q       <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         pulses_q  <= pulses_d;
         error_q   <= error_d;
         done_q    <= done_d;
         trig_q    <= trig_d;
         if (accept) begin
            fg_last_q    <= (cfg_fg_delay == '0) ? '0 : cfg_fg_delay - CNT_W'(1);
            phase_last_q <= (cfg_phase_shift == '0) ? '0 : cfg_phase_shift - CNT_W'(1);
            len_last_q   <= (cfg_trig_len == '0) ? '0 : cfg_trig_len - CNT_W'(1);
            mask_q       <= cfg_ch_mask;
         end
      end
   end

   assign output_trigger = trig_q;
   assign busy           = (state_q != StIdle);
   assign done           = done_q;
   assign error_timeout  = error_q;

endmodule

// File: tb/tb_fsm_trigger_sequencer.sv
// Directed bench for fsm_trigger_sequencer. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so "step i" below means
// "just after the i-th edge following the stimulus event".
module tb_fsm_trigger_sequencer;

   localparam int unsigned N_CH        = 4;
   localparam int unsigned CNT_W       = 32;
   localparam int unsigned BURST_W     = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned TIMEOUT     = 1000;

   logic               clock = 1'b0;
   logic               reset;
   logic               start_signal;
   logic               abort;
   logic               fg_signal;
   logic               phase_signal;
   logic [CNT_W-1:0]   cfg_fg_delay;
   logic [CNT_W-1:0]   cfg_phase_shift;
   logic [CNT_W-1:0]   cfg_trig_len;
   logic [BURST_W-1:0] cfg_burst;
   logic [N_CH-1:0]    cfg_ch_mask;
   logic [N_CH-1:0]    output_trigger;
   logic               busy;
   logic               done;
   logic               error_timeout;

   int tests  = 0;
   int failed = 0;

   fsm_trigger_sequencer #(
      .N_CH       (N_CH),
      .CNT_W      (CNT_W),
      .BURST_W    (BURST_W),
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start_signal   (start_signal),
      .abort          (abort),
      .fg_signal      (fg_signal),
      .phase_signal   (phase_signal),
      .cfg_fg_delay   (cfg_fg_delay),
      .cfg_phase_shift(cfg_phase_shift),
      .cfg_trig_len   (cfg_trig_len),
      .cfg_burst      (cfg_burst),
      .cfg_ch_mask    (cfg_ch_mask),
      .output_trigger (output_trigger),
      .busy           (busy),
      .done           (done),
      .error_timeout  (error_timeout)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      start_signal = 1'b0;
      abort        = 1'b0;
      fg_signal    = 1'b0;
      phase_signal = 1'b0;
      repeat (6) tick();
   endtask

   task automatic set_cfg(input logic [CNT_W-1:0] fgd, input logic [CNT_W-1:0] ps,
                          input logic [CNT_W-1:0] len, input logic [BURST_W-1:0] b,
                          input logic [N_CH-1:0] m);
      cfg_fg_delay    = fgd;
      cfg_phase_shift = ps;
      cfg_trig_len    = len;
      cfg_burst       = b;
      cfg_ch_mask     = m;
   endtask

   task automatic start_run();
      start_signal = 1'b1;
      tick();
      start_signal = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start_signal = 1'b0;
      abort = 1'b0;
      fg_signal = 1'b0;
      phase_signal = 1'b0;
      set_cfg(32'd0, 32'd0, 32'd0, 8'd0, 4'b0000);
      repeat (3) tick();
      tests++;
      if ({output_trigger, done, busy, error_timeout} !== 7'b0) begin
         failed++;
         $display("FAIL reset_state: got trig=%b done=%b busy=%b err=%b want all 0",
                  output_trigger, done, busy, error_timeout);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_shot();
      logic [5:0] exp;
      set_cfg(32'd10, 32'd139, 32'd100, 8'd1, 4'b0101);
      start_run();
      tests++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL single_busy_after_start: got %b want 1", busy);
      end
      // Must not affect the run already started.
      set_cfg(32'd3, 32'd2, 32'd5, 8'd4, 4'b1111);
      fg_signal = 1'b1;
      repeat (63) tick();
      phase_signal = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         tick();
         if (i == 10) phase_signal = 1'b0;
         exp = {((i >= 142 && i <= 241) ? 4'b0101 : 4'b0000), (i == 242), (i < 242)};
         tests++;
         if ({output_trigger, done, busy} !== exp) begin
            failed++;
            $display("FAIL single_shot step %0d: got trig/done/busy=%b want %b", i,
                     {output_trigger, done, busy}, exp);
         end
      end
      settle();
   endtask

   task automatic test_burst();
      logic [5:0] exp;
      logic       hi;
      set_cfg(32'd10, 32'd139, 32'd20, 8'd3, 4'b1111);
      start_run();
      fg_signal = 1'b1;
      repeat (20) tick();
      phase_signal = 1'b1;
      for (int i = 1; i <= 800; i++) begin
         tick();
         // Edges at 0, 300, 600; the one at 145 lands inside the first pulse.
         phase_signal = (i < 10) || (i >= 145 && i < 155) || (i >= 300 && i < 310) ||
                        (i >= 600 && i < 610);
         hi = (i >= 142 && i <= 161) || (i >= 442 && i <= 461) || (i >= 742 && i <= 761);
         exp = {(hi ? 4'b1111 : 4'b0000), (i == 762), (i < 762)};
         tests++;
         if ({output_trigger, done, busy} !== exp) begin
            failed++;
            $display("FAIL burst step %0d: got trig/done/busy=%b want %b", i,
                     {output_trigger, done, busy}, exp);
         end
      end
      settle();
   endtask

   task automatic test_timeout();
      logic [6:0] exp;
      set_cfg(32'd10, 32'd139, 32'd100, 8'd1, 4'b0001);
      start_run();
      for (int i = 1; i <= 1005; i++) begin
         tick();
         exp = {4'b0000, 1'b0, (i < 1000), (i >= 1000)};
         tests++;
         if ({output_trigger, done, busy, error_timeout} !== exp) begin
            failed++;
            $display("FAIL timeout step %0d: got trig/done/busy/err=%b want %b", i,
                     {output_trigger, done, busy, error_timeout}, exp);
         end
      end
      start_run();
      tests++;
      if ({error_timeout, busy} !== 2'b01) begin
         failed++;
         $display("FAIL timeout_clear_on_start: got err/busy=%b want 01",
                  {error_timeout, busy});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         failed++;
         $display("FAIL abort_in_wait_fg: got busy=%b want 0", busy);
      end
      settle();
   endtask

   task automatic test_abort();
      start_signal = 1'b1;
      abort = 1'b1;
      tick();
      start_signal = 1'b0;
      abort = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         failed++;
         $display("FAIL start_with_abort: got busy=%b want 0", busy);
      end
      set_cfg(32'd10, 32'd139, 32'd100, 8'd1, 4'b0011);
      start_run();
      fg_signal = 1'b1;
      repeat (20) tick();
      phase_signal = 1'b1;
      for (int i = 1; i <= 181; i++) begin
         tick();
         if (i == 10) phase_signal = 1'b0;
      end
      tests++;
      if ({output_trigger, done, busy} !== 6'b0011_0_1) begin
         failed++;
         $display("FAIL abort_pulse_cycle40: got trig/done/busy=%b want 001101",
                  {output_trigger, done, busy});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tests++;
      if ({output_trigger, done, busy, error_timeout} !== 7'b0) begin
         failed++;
         $display("FAIL abort_next_cycle: got trig/done/busy/err=%b want 0000000",
                  {output_trigger, done, busy, error_timeout});
      end
      for (int j = 1; j <= 400; j++) begin
         tick();
         if (j == 5) phase_signal = 1'b1;
         if (j == 15) phase_signal = 1'b0;
         tests++;
         if ({output_trigger, done, busy} !== 6'b0) begin
            failed++;
            $display("FAIL after_abort step %0d: got trig/done/busy=%b want 000000", j,
                     {output_trigger, done, busy});
         end
      end
      settle();
   endtask

   task automatic test_zero_cfg();
      logic [5:0] exp;
      set_cfg(32'd0, 32'd0, 32'd0, 8'd0, 4'b1000);
      start_run();
      fg_signal = 1'b1;
      repeat (10) tick();
      phase_signal = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 3) phase_signal = 1'b0;
         exp = {((i == 4) ? 4'b1000 : 4'b0000), (i == 5), (i < 5)};
         tests++;
         if ({output_trigger, done, busy} !== exp) begin
            failed++;
            $display("FAIL zero_cfg step %0d: got trig/done/busy=%b want %b", i,
                     {output_trigger, done, busy}, exp);
         end
      end
      settle();
   endtask

   task automatic test_reset_mid_run();
      set_cfg(32'd10, 32'd139, 32'd100, 8'd1, 4'b1111);
      start_run();
      fg_signal = 1'b1;
      repeat (20) tick();
      phase_signal = 1'b1;
      repeat (50) tick();
      tests++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL busy_in_phase_delay: got %b want 1", busy);
      end
      reset = 1'b1;
      start_signal = 1'b1;
      tick();
      tests++;
      if ({output_trigger, done, busy, error_timeout} !== 7'b0) begin
         failed++;
         $display("FAIL reset_mid_run: got trig/done/busy/err=%b want 0000000",
                  {output_trigger, done, busy, error_timeout});
      end
      reset = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b1) begin
         failed++;
         $display("FAIL start_after_reset: got busy=%b want 1", busy);
      end
      start_signal = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      settle();
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_burst();
      test_timeout();
      test_abort();
      test_zero_cfg();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
